riscv_alu_seq: RTL and testbench

Parametrised, sequential successor to the single-cycle RV32I ALU. It executes all base integer ALU operations with one registered cycle of latency. It also executes the RV M-extension operations (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) iteratively over XLEN cycles. It sits in the execute stage, uses a valid/ready request handshake, and accepts a kill for pipeline flushes.

---
 rtl/riscv_alu_seq_if.sv | 27 ++
 rtl/riscv_alu_seq.sv | 196 +++++++++++++++++++
 tb/tb_riscv_alu_seq.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_alu_seq_if.sv
// Request/response bundle for the sequential RV32I/M ALU.
interface riscv_alu_seq_if #(
  parameter int unsigned XLEN = 32
);
  logic            i_valid;
  logic            o_ready;
  logic [XLEN-1:0] i_alu_a;
  logic [XLEN-1:0] i_alu_b;
  logic [4:0]      i_alu_ctrl;
  logic            i_kill;
  logic            o_valid;
  logic [XLEN-1:0] o_alu_result;
  logic            o_alu_zero;
  logic            o_busy;

  // Pipeline side that issues operations.
  modport master (
    output i_valid, i_alu_a, i_alu_b, i_alu_ctrl, i_kill,
    input  o_ready, o_valid, o_alu_result, o_alu_zero, o_busy
  );

  // ALU side.
  modport slave (
    input  i_valid, i_alu_a, i_alu_b, i_alu_ctrl, i_kill,
    output o_ready, o_valid, o_alu_result, o_alu_zero, o_busy
  );
endinterface

// File: rtl/riscv_alu_seq.sv
// Sequential RV32I ALU with iterative M-extension multiply/divide.
// Base ops complete in one registered cycle; MUL*/DIV* iterate XLEN cycles.
// Base op codes (ctrl[3:0]): 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR,
// 6 SRL, 7 SRA, 8 OR, 9 AND; other codes return 0.
module riscv_alu_seq #(
  parameter int unsigned XLEN = 32,
  localparam int unsigned SHW = $clog2(XLEN)
) (
  input logic            i_clk,
  input logic            i_rst,
  riscv_alu_seq_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e          state_q, state_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d;    // mul partial-product high / div partial remainder
  logic [XLEN-1:0] lo_q, lo_d;    // multiplier bits / dividend-then-quotient bits
  logic [XLEN-1:0] opb_q, opb_d;  // multiplicand or divisor magnitude
  logic [2:0]      fn_q, fn_d;
  logic            neg_q, neg_d, neg_rem_q, neg_rem_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;

  logic [XLEN-1:0]   a, b, a_mag, b_mag, base_res;
  logic [4:0]        ctrl;
  logic [SHW-1:0]    shamt;
  logic              accept, a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN:0]     mul_sum, div_trial;
  logic [2*XLEN-1:0] mul_prod, mul_prod_s;
  logic [XLEN-1:0]   div_rem, div_quo;

  assign a      = bus.i_alu_a;
  assign b      = bus.i_alu_b;
  assign ctrl   = bus.i_alu_ctrl;
  assign shamt  = b[SHW-1:0];
  assign accept = bus.i_valid && bus.o_ready && !bus.i_kill;

  assign bus.o_ready      = (state_q == StIdle) && !i_rst;
  assign bus.o_valid      = valid_q;
  assign bus.o_alu_result = result_q;
  assign bus.o_alu_zero   = zero_q;
  assign bus.o_busy       = (state_q != StIdle);

  // Single-cycle base operations.
  always_comb begin
    base_res = '0;
    case (ctrl[3:0])
      4'd0:    base_res = a + b;
      4'd1:    base_res = a - b;
      4'd2:    base_res = a << shamt;
      4'd3:    base_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd4:    base_res = {{(XLEN-1){1'b0}}, (a < b)};
      4'd5:    base_res = a ^ b;
      4'd6:    base_res = a >> shamt;
      4'd7:    base_res = $signed(a) >>> shamt;
      4'd8:    base_res = a | b;
      4'd9:    base_res = a & b;
      default: base_res = '0;
    endcase
  end

  // Operand signedness per M funct3; MULHSU is the only mixed case.
  always_comb begin
    if (ctrl[2]) begin
      a_sgn = !ctrl[0];
      b_sgn = !ctrl[0];
    end else begin
      a_sgn = (ctrl[1:0] != 2'b11);
      b_sgn = !ctrl[1];
    end
    a_neg = a_sgn && a[XLEN-1];
    b_neg = b_sgn && b[XLEN-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // One shift-add and one restoring-division step from the current registers.
  always_comb begin
    mul_sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    mul_prod   = {mul_sum, lo_q[XLEN-1:1]};
    mul_prod_s = neg_q ? -mul_prod : mul_prod;
    div_trial  = {hi_q, lo_q[XLEN-1]} - {1'b0, opb_q};
    if (!div_trial[XLEN]) begin
      div_rem = div_trial[XLEN-1:0];
      div_quo = {lo_q[XLEN-2:0], 1'b1};
    end else begin
      div_rem = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
      div_quo = {lo_q[XLEN-2:0], 1'b0};
    end
  end

  // Next-state: accept, iterate, finish; kill overrides everything.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opb_d     = opb_q;
    fn_d      = fn_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    valid_d   = 1'b0;
    result_d  = result_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          fn_d = ctrl[2:0];
          if (!ctrl[4]) begin
            result_d = base_res;
            valid_d  = 1'b1;
          end else if (!ctrl[2]) begin
            hi_d    = '0;
            lo_d    = a_mag;
            opb_d   = b_mag;
            neg_d   = a_neg ^ b_neg;
            cnt_d   = SHW'(XLEN - 1);
            state_d = StMul;
          end else if (b == '0) begin
            result_d = ctrl[1] ? a : '1;
            valid_d  = 1'b1;
          end else if (!ctrl[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1)) begin
            result_d = ctrl[1] ? '0 : a;
            valid_d  = 1'b1;
          end else begin
            hi_d      = '0;
            lo_d      = a_mag;
            opb_d     = b_mag;
            neg_d     = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            cnt_d     = SHW'(XLEN - 1);
            state_d   = StDiv;
          end
        end
      end
      StMul: begin
        hi_d  = mul_sum[XLEN:1];
        lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          result_d = (fn_q == 3'b000) ? mul_prod_s[XLEN-1:0] : mul_prod_s[2*XLEN-1:XLEN];
          valid_d  = 1'b1;
          state_d  = StIdle;
        end
      end
      StDiv: begin
        hi_d  = div_rem;
        lo_d  = div_quo;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          if (fn_q[1]) result_d = neg_rem_q ? -div_rem : div_rem;
          else         result_d = neg_q ? -div_quo : div_quo;
          valid_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (bus.i_kill) begin
      state_d  = StIdle;
      valid_d  = 1'b0;
      result_d = result_q;
    end
    zero_d = (result_d == '0);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opb_q     <= '0;
      fn_q      <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      valid_q   <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opb_q     <= opb_d;
      fn_q      <= fn_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      valid_q   <= valid_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
    end
  end
endmodule

// File: tb/tb_riscv_alu_seq.sv
// Self-checking bench for riscv_alu_seq (XLEN=32 and XLEN=16 instances).
module tb_riscv_alu_seq;
  localparam logic [4:0] OpAdd = 5'd0, OpSub = 5'd1, OpSll = 5'd2, OpSra = 5'd7;
  localparam logic [4:0] OpMul = 5'h10, OpMulh = 5'h11, OpMulhsu = 5'h12, OpMulhu = 5'h13;
  localparam logic [4:0] OpDiv = 5'h14, OpDivu = 5'h15, OpRem = 5'h16, OpRemu = 5'h17;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  riscv_alu_seq_if #(.XLEN(32)) b32 ();
  riscv_alu_seq_if #(.XLEN(16)) b16 ();

  riscv_alu_seq #(.XLEN(32)) u_dut32 (.i_clk(clk), .i_rst(rst), .bus(b32));
  riscv_alu_seq #(.XLEN(16)) u_dut16 (.i_clk(clk), .i_rst(rst), .bus(b16));

  // Reference: plain wide arithmetic on the RISC-V definitions.
  function automatic logic [63:0] model(input int w, input logic [4:0] c,
                                        input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] one, m, ua, ub, sa, sb, r;
    int sh;
    one = 128'sd1;
    m   = (one <<< w) - one;
    ua  = 128'(a) & m;
    ub  = 128'(b) & m;
    sa  = ua[w-1] ? ua - (one <<< w) : ua;
    sb  = ub[w-1] ? ub - (one <<< w) : ub;
    sh  = int'(ub[5:0]) & (w - 1);
    r   = '0;
    if (!c[4]) begin
      case (c[3:0])
        4'd0: r = ua + ub;
        4'd1: r = ua - ub;
        4'd2: r = ua << sh;
        4'd3: r = (sa < sb) ? one : '0;
        4'd4: r = (ua < ub) ? one : '0;
        4'd5: r = ua ^ ub;
        4'd6: r = ua >> sh;
        4'd7: r = sa >>> sh;
        4'd8: r = ua | ub;
        4'd9: r = ua & ub;
        default: r = '0;
      endcase
    end else begin
      case (c[2:0])
        3'd0: r = sa * sb;
        3'd1: r = (sa * sb) >>> w;
        3'd2: r = (sa * ub) >>> w;
        3'd3: r = (ua * ub) >>> w;
        3'd4: r = (ub == 0) ? -one : sa / sb;
        3'd5: r = (ub == 0) ? -one : ua / ub;
        3'd6: r = (ub == 0) ? sa : sa % sb;
        default: r = (ub == 0) ? ua : ua % ub;
      endcase
    end
    return r[63:0] & m[63:0];
  endfunction

  // Latency the model expects: one cycle unless an iterative M op.
  function automatic int model_lat(input int w, input logic [4:0] c,
                                   input logic [63:0] a, input logic [63:0] b);
    logic [63:0] m, mn;
    m  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    mn = 64'd1 << (w - 1);
    if (!c[4]) return 1;
    if (!c[2]) return w + 1;
    if ((b & m) == 0) return 1;
    if (!c[0] && ((a & m) == mn) && ((b & m) == m)) return 1;
    return w + 1;
  endfunction

  // Issue one op on the selected instance and observe its completion.
  task automatic run_op(input bit narrow, input logic [4:0] c, input logic [63:0] a,
                        input logic [63:0] b, output logic [63:0] res, output logic zero,
                        output int lat, output int busy_cyc, output int ready_hi,
                        output logic rdy_v, output logic busy_v);
    logic ov;
    @(negedge clk);
    if (narrow) begin
      b16.i_valid = 1'b1; b16.i_alu_ctrl = c; b16.i_alu_a = a[15:0]; b16.i_alu_b = b[15:0];
    end else begin
      b32.i_valid = 1'b1; b32.i_alu_ctrl = c; b32.i_alu_a = a[31:0]; b32.i_alu_b = b[31:0];
    end
    @(negedge clk);
    b16.i_valid = 1'b0; b32.i_valid = 1'b0;
    // Operand changes after accept must not matter.
    b16.i_alu_a = 16'($urandom); b16.i_alu_b = 16'($urandom); b16.i_alu_ctrl = 5'($urandom);
    b32.i_alu_a = $urandom; b32.i_alu_b = $urandom; b32.i_alu_ctrl = 5'($urandom);
    lat = 0; busy_cyc = 0; ready_hi = 0; res = '0; zero = 1'b0; rdy_v = 1'b0; busy_v = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      ov = narrow ? b16.o_valid : b32.o_valid;
      if (ov) begin
        lat    = k;
        res    = narrow ? 64'(b16.o_alu_result) : 64'(b32.o_alu_result);
        zero   = narrow ? b16.o_alu_zero : b32.o_alu_zero;
        rdy_v  = narrow ? b16.o_ready : b32.o_ready;
        busy_v = narrow ? b16.o_busy : b32.o_busy;
        break;
      end
      if (narrow ? b16.o_busy : b32.o_busy) busy_cyc++;
      if (narrow ? b16.o_ready : b32.o_ready) ready_hi++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (b32.o_ready !== 1'b0) $display("FAIL reset_ready got=%b want=0", b32.o_ready); else passed++;
    checks++; if (b32.o_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", b32.o_valid); else passed++;
    checks++; if (b32.o_alu_result !== 32'h0) $display("FAIL reset_result got=%h want=0", b32.o_alu_result); else passed++;
    checks++; if (b32.o_alu_zero !== 1'b1) $display("FAIL reset_zero got=%b want=1", b32.o_alu_zero); else passed++;
    checks++; if (b32.o_busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", b32.o_busy); else passed++;
    checks++; if (b16.o_alu_zero !== 1'b1) $display("FAIL reset_zero16 got=%b want=1", b16.o_alu_zero); else passed++;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (b32.o_ready !== 1'b1) $display("FAIL reset_ready_after got=%b want=1", b32.o_ready); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_r [3];
    logic [4:0]  ops [3];
    logic [31:0] as [3];
    logic [31:0] bs [3];
    ops = '{OpAdd, OpSub, OpSra};
    as  = '{32'd5, 32'd5, 32'h8000_0000};
    bs  = '{32'd7, 32'd7, 32'd31};
    exp_r = '{32'd12, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        checks++; if (b32.o_valid !== 1'b1) $display("FAIL b2b_valid%0d got=%b want=1", i, b32.o_valid); else passed++;
        checks++; if (b32.o_alu_result !== exp_r[i-1]) $display("FAIL b2b_result%0d got=%h want=%h", i, b32.o_alu_result, exp_r[i-1]); else passed++;
        checks++; if (b32.o_alu_zero !== 1'b0) $display("FAIL b2b_zero%0d got=%b want=0", i, b32.o_alu_zero); else passed++;
      end
      if (i < 3) begin
        checks++; if (b32.o_ready !== 1'b1) $display("FAIL b2b_ready%0d got=%b want=1", i, b32.o_ready); else passed++;
        b32.i_valid = 1'b1; b32.i_alu_ctrl = ops[i]; b32.i_alu_a = as[i]; b32.i_alu_b = bs[i];
      end else begin
        b32.i_valid = 1'b0;
      end
      @(negedge clk);
    end
    checks++; if (b32.o_valid !== 1'b0) $display("FAIL b2b_valid_end got=%b want=0", b32.o_valid); else passed++;
  endtask

  task automatic test_directed_m();
    logic [4:0]  ops [12];
    logic [31:0] as [12];
    logic [31:0] bs [12];
    logic [31:0] ex [12];
    int          el [12];
    logic [63:0] res;
    logic        zero, rdy_v, busy_v;
    int          lat, bc, rh;
    ops = '{OpMulh, OpMulhu, OpMulhsu, OpMul, OpDiv, OpRem, OpDivu, OpRemu,
            OpDiv, OpRemu, OpDiv, OpRem};
    as  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
            32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    bs  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFC, 32'd2, 32'd2,
            32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    ex  = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 32'hFFFF_FFFD,
            32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    el  = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1};
    for (int i = 0; i < 12; i++) begin
      run_op(1'b0, ops[i], 64'(as[i]), 64'(bs[i]), res, zero, lat, bc, rh, rdy_v, busy_v);
      checks++; if (res[31:0] !== ex[i]) $display("FAIL m_result%0d got=%h want=%h", i, res[31:0], ex[i]); else passed++;
      checks++; if (zero !== (ex[i] == 32'd0)) $display("FAIL m_zero%0d got=%b want=%b", i, zero, ex[i] == 32'd0); else passed++;
      checks++; if (lat !== el[i]) $display("FAIL m_latency%0d got=%0d want=%0d", i, lat, el[i]); else passed++;
      checks++; if (rh !== 0 || rdy_v !== 1'b1) $display("FAIL m_ready%0d got=%0d/%b want=0/1", i, rh, rdy_v); else passed++;
      checks++; if (bc !== el[i] - 1 || busy_v !== 1'b0) $display("FAIL m_busy%0d got=%0d/%b want=%0d/0", i, bc, busy_v, el[i] - 1); else passed++;
    end
  endtask

  task automatic test_random();
    logic [63:0] res, a, b, e;
    logic [4:0]  c;
    logic        zero, rdy_v, busy_v, nar;
    int          lat, bc, rh, w, el;
    logic [63:0] corner [4];
    corner = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_8000, 64'h1};
    for (int i = 0; i < 60; i++) begin
      nar = 1'($urandom);
      w   = nar ? 16 : 32;
      if (i < 30) c = 5'($urandom_range(0, 15));
      else        c = {2'b10, 3'($urandom)};
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) a = (w == 16) ? (corner[$urandom_range(0, 3)] & 64'h8000 ? 64'h8000 : 64'h0) : 64'h8000_0000;
      if ($urandom_range(0, 3) == 0) b = corner[$urandom_range(0, 3)];
      if ($urandom_range(0, 7) == 0) b = a;
      e  = model(w, c, a, b);
      el = model_lat(w, c, a, b);
      run_op(nar, c, a, b, res, zero, lat, bc, rh, rdy_v, busy_v);
      checks++; if (res !== e) $display("FAIL rand_result%0d w=%0d ctrl=%h a=%h b=%h got=%h want=%h", i, w, c, a, b, res, e); else passed++;
      checks++; if (zero !== (e == 64'd0)) $display("FAIL rand_zero%0d got=%b want=%b", i, zero, e == 64'd0); else passed++;
      checks++; if (lat !== el) $display("FAIL rand_latency%0d w=%0d ctrl=%h got=%0d want=%0d", i, w, c, lat, el); else passed++;
    end
  endtask

  task automatic test_kill();
    logic [31:0] prev;
    logic [63:0] res;
    logic        zero, rdy_v, busy_v;
    int          lat, bc, rh, seen;
    int          kill_at [2];
    kill_at = '{10, 32};
    for (int j = 0; j < 2; j++) begin
      prev = b32.o_alu_result;
      @(negedge clk);
      b32.i_valid = 1'b1; b32.i_alu_ctrl = OpDivu; b32.i_alu_a = 32'd100; b32.i_alu_b = 32'd7;
      @(negedge clk);
      b32.i_valid = 1'b0;
      repeat (kill_at[j] - 1) @(negedge clk);
      b32.i_kill = 1'b1;
      @(negedge clk);
      b32.i_kill = 1'b0;
      checks++; if (b32.o_busy !== 1'b0 || b32.o_ready !== 1'b1) $display("FAIL kill_state%0d got busy=%b ready=%b want busy=0 ready=1", j, b32.o_busy, b32.o_ready); else passed++;
      seen = 0;
      repeat (40) begin
        if (b32.o_valid) seen++;
        @(negedge clk);
      end
      checks++; if (seen !== 0) $display("FAIL kill_no_valid%0d got=%0d want=0", j, seen); else passed++;
      checks++; if (b32.o_alu_result !== prev) $display("FAIL kill_result_held%0d got=%h want=%h", j, b32.o_alu_result, prev); else passed++;
      run_op(1'b0, OpAdd, 64'd1, 64'd1, res, zero, lat, bc, rh, rdy_v, busy_v);
      checks++; if (res[31:0] !== 32'd2 || lat !== 1) $display("FAIL kill_next_add%0d got=%h lat=%0d want=2 lat=1", j, res[31:0], lat); else passed++;
    end
    // Request presented together with kill is dropped.
    prev = b32.o_alu_result;
    @(negedge clk);
    b32.i_valid = 1'b1; b32.i_kill = 1'b1; b32.i_alu_ctrl = OpAdd; b32.i_alu_a = 32'd9; b32.i_alu_b = 32'd9;
    @(negedge clk);
    b32.i_valid = 1'b0; b32.i_kill = 1'b0;
    checks++; if (b32.o_valid !== 1'b0 || b32.o_alu_result !== prev) $display("FAIL kill_drop got valid=%b res=%h want valid=0 res=%h", b32.o_valid, b32.o_alu_result, prev); else passed++;
  endtask

  task automatic test_reset_mid_op();
    int seen;
    @(negedge clk);
    b32.i_valid = 1'b1; b32.i_alu_ctrl = OpMul; b32.i_alu_a = 32'd1234; b32.i_alu_b = 32'd77;
    @(negedge clk);
    b32.i_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (b32.o_ready !== 1'b0) $display("FAIL rst_mid_ready got=%b want=0", b32.o_ready); else passed++;
    @(negedge clk);
    checks++; if (b32.o_busy !== 1'b0 || b32.o_valid !== 1'b0) $display("FAIL rst_mid_ctrl got busy=%b valid=%b want 0/0", b32.o_busy, b32.o_valid); else passed++;
    checks++; if (b32.o_alu_result !== 32'h0 || b32.o_alu_zero !== 1'b1) $display("FAIL rst_mid_result got=%h zero=%b want=0 zero=1", b32.o_alu_result, b32.o_alu_zero); else passed++;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (b32.o_ready !== 1'b1) $display("FAIL rst_mid_ready_after got=%b want=1", b32.o_ready); else passed++;
    seen = 0;
    repeat (40) begin
      if (b32.o_valid) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) $display("FAIL rst_mid_no_valid got=%0d want=0", seen); else passed++;
  endtask

  task automatic test_xlen16();
    logic [63:0] res;
    logic        zero, rdy_v, busy_v;
    int          lat, bc, rh;
    run_op(1'b1, OpMulhu, 64'hFFFF, 64'hFFFF, res, zero, lat, bc, rh, rdy_v, busy_v);
    checks++; if (res !== 64'hFFFE || lat !== 17) $display("FAIL x16_mulhu got=%h lat=%0d want=fffe lat=17", res, lat); else passed++;
    checks++; if (bc !== 16 || rh !== 0) $display("FAIL x16_busy got busy=%0d ready=%0d want 16/0", bc, rh); else passed++;
    run_op(1'b1, OpSll, 64'h1, 64'h13, res, zero, lat, bc, rh, rdy_v, busy_v);
    checks++; if (res !== 64'h8 || lat !== 1) $display("FAIL x16_sll got=%h lat=%0d want=8 lat=1", res, lat); else passed++;
  endtask

  initial begin
    b32.i_valid = 1'b0; b32.i_kill = 1'b0; b32.i_alu_a = '0; b32.i_alu_b = '0; b32.i_alu_ctrl = '0;
    b16.i_valid = 1'b0; b16.i_kill = 1'b0; b16.i_alu_a = '0; b16.i_alu_b = '0; b16.i_alu_ctrl = '0;
    test_reset();
    test_back_to_back();
    test_directed_m();
    test_random();
    test_kill();
    test_reset_mid_op();
    test_xlen16();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "timeout");
  end
endmodule
